// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM states, channel limit and index helpers for the interrupt request unit.
// Pure definitions: no logic, no latency, no backpressure.
package irq_pkg;

  localparam int IRQ_MAX = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    ACK2
  } irq_state_e;

  // Vector reported when the first inta found nothing to serve.
  function automatic int spurious_idx(input int num_irq);
    return num_irq - 1;
  endfunction

  // Channel holding rank k when rank 0 sits at base; base + k never reaches 2*num_irq.
  function automatic int rot_idx(input int base, input int k, input int num_irq);
    int s;
    s = base + k;
    return (s >= num_irq) ? s - num_irq : s;
  endfunction

endpackage

// File: rtl/irq_priority_resolver.sv
// irq_priority_resolver: combinational rotated-priority pick of the winning request and the top in-service channel.
// Zero latency, no backpressure; base selects which channel currently holds highest priority.
module irq_priority_resolver
  import irq_pkg::*;
#(
  parameter  int NUM_IRQ = 8,
  localparam int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [NUM_IRQ-1:0] isr,
  input  logic [IDX_W-1:0]   base,
  output logic               win_vld,
  output logic [IDX_W-1:0]   win_idx,
  output logic               top_vld,
  output logic [IDX_W-1:0]   top_idx
);

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] req_rank;
  logic [IDX_W-1:0] top_rank;
  logic             req_hit;

  always_comb begin
    idx      = '0;
    req_rank = '0;
    top_rank = '0;
    req_hit  = 1'b0;
    win_idx  = '0;
    top_idx  = '0;
    top_vld  = 1'b0;
    // Walk from lowest to highest priority so the last hit is the best one.
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      idx = IDX_W'(rot_idx(int'(base), k, NUM_IRQ));
      if (req[idx]) begin
        req_hit  = 1'b1;
        win_idx  = idx;
        req_rank = IDX_W'(k);
      end
      if (isr[idx]) begin
        top_vld  = 1'b1;
        top_idx  = idx;
        top_rank = IDX_W'(k);
      end
    end
    win_vld = req_hit && (!top_vld || (req_rank < top_rank));
  end

endmodule

// File: rtl/irq_request_unit.sv
// irq_request_unit: nested-priority IRR/ISR tracking with a two-pulse INTA vector handshake; int_out one cycle after a winner.
// No backpressure; define IRQ_ROTATE_EN for automatic rotation of priority on each effective eoi.
module irq_request_unit
  import irq_pkg::*;
#(
  parameter  int NUM_IRQ = 8,
  localparam int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic [NUM_IRQ-1:0] level_mode,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               inta,
  input  logic               eoi,
  output logic               int_out,
  output logic [IDX_W-1:0]   vector_idx,
  output logic               vector_valid,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr
);

  if (NUM_IRQ < 2 || NUM_IRQ > IRQ_MAX) begin : g_bad_num_irq
    $error("irq_request_unit: NUM_IRQ out of range");
  end

  irq_state_e         state;
  logic [NUM_IRQ-1:0] prev_lines;
  logic [NUM_IRQ-1:0] isr_set;
  logic [NUM_IRQ-1:0] isr_clr;
  logic [NUM_IRQ-1:0] irr_clr;
  logic [NUM_IRQ-1:0] irr_nxt;
  logic [IDX_W-1:0]   rot_base;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   top_idx;
  logic [IDX_W-1:0]   ack_idx;
  logic               win_vld;
  logic               top_vld;

  irq_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_resolver (
    .req     (irr & ~irq_mask),
    .isr     (isr),
    .base    (rot_base),
    .win_vld (win_vld),
    .win_idx (win_idx),
    .top_vld (top_vld),
    .top_idx (top_idx)
  );

`ifdef IRQ_ROTATE_EN
  // The channel just retired drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_base <= '0;
    end else if (eoi && top_vld) begin
      rot_base <= (top_idx == IDX_W'(NUM_IRQ - 1)) ? '0 : top_idx + 1'b1;
    end
  end
`else
  assign rot_base = '0;
`endif

  always_comb begin
    isr_set = '0;
    isr_clr = '0;
    irr_clr = '0;
    if (eoi && top_vld) isr_clr[top_idx] = 1'b1;
    if (state == ACK1 && win_vld) begin
      isr_set[win_idx] = 1'b1;
      irr_clr[win_idx] = ~level_mode[win_idx];
    end
    // A fresh edge outranks the acknowledge clear.
    irr_nxt = (level_mode & irq_lines)
            | (~level_mode & ((irq_lines & ~prev_lines) | (irr & ~irr_clr)));
  end

  // Winner is sampled in ACK1, after any eoi issued alongside the first inta has landed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      prev_lines   <= '0;
      irr          <= '0;
      isr          <= '0;
      int_out      <= 1'b0;
      vector_idx   <= '0;
      vector_valid <= 1'b0;
      ack_idx      <= '0;
    end else begin
      prev_lines   <= irq_lines;
      irr          <= irr_nxt;
      isr          <= (isr & ~isr_clr) | isr_set;
      int_out      <= win_vld;
      vector_valid <= 1'b0;
      case (state)
        IDLE: if (inta) state <= ACK1;
        ACK1: begin
          ack_idx <= win_vld ? win_idx : IDX_W'(spurious_idx(NUM_IRQ));
          state   <= ACK2;
        end
        ACK2: if (inta) begin
          vector_valid <= 1'b1;
          vector_idx   <= ack_idx;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/irq_request_unit.md
IRQ_REQUEST_UNIT -- requirements
Module: irq_request_unit

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of request channels, legal range 2..16.
REQ-002 SHALL derive IDX_W = clog2(NUM_IRQ) internally; it is not overridable.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port irq_lines, input, NUM_IRQ, raw requests, already synchronised to clk.
REQ-006 SHALL have port level_mode, input, NUM_IRQ, per channel: 1 = level, 0 = rising edge.
REQ-007 SHALL have port irq_mask, input, NUM_IRQ, 1 = channel masked.
REQ-008 SHALL have port inta, input, 1, one-cycle acknowledge pulse per INTA cycle.
REQ-009 SHALL have port eoi, input, 1, one-cycle non-specific end-of-interrupt pulse.
REQ-010 SHALL have port int_out, output, 1, interrupt request to CPU.
REQ-011 SHALL have port vector_idx, output, IDX_W, acknowledged channel index.
REQ-012 SHALL have port vector_valid, output, 1, vector_idx qualifier, one cycle.
REQ-013 SHALL have ports irr and isr, output, NUM_IRQ each, request and in-service registers.

Function
REQ-014 Edge channel: IRR bit SHALL set in the cycle after a 0->1 on its line (registered previous value) and hold until acknowledged.
REQ-015 Level channel: IRR bit SHALL equal the line value registered one cycle earlier.
REQ-016 Masked channels SHALL still latch IRR but SHALL NOT take part in resolution.
REQ-017 Priority SHALL be fixed: lowest index = highest priority, unless REQ-030 applies.
REQ-018 Winner = highest-priority unmasked IRR bit strictly higher in priority than every set ISR bit (fully nested).
REQ-019 int_out SHALL be registered: high in the cycle after a winner exists, low in the cycle after none exists.
REQ-020 The FSM SHALL have states IDLE, ACK1 and ACK2; an inta in IDLE moves it to ACK1 and freezes the winner.
REQ-021 On entering ACK1 with a valid winner, it SHALL set the ISR bit, clear the IRR bit (edge channels only) and move to ACK2.
REQ-022 An inta in ACK2 SHALL drive vector_idx with vector_valid high for exactly one cycle, then return to IDLE.
REQ-023 With no winner at the first inta (spurious), it SHALL report index NUM_IRQ-1 at the second inta and leave ISR and IRR unchanged.
REQ-024 Each eoi SHALL clear the highest-priority set ISR bit; eoi with ISR empty SHALL be ignored.
REQ-025 eoi and inta in the same cycle SHALL both take effect; eoi clears the ISR first, then ACK1 resolution uses the updated ISR.
REQ-026 A line edge in the same cycle as clearing that IRR bit SHALL leave the bit set (set wins).

Reset
REQ-027 With rst_n low: irr, isr, int_out, vector_idx, vector_valid SHALL be 0, the FSM SHALL be IDLE and the line history SHALL be 0.
REQ-028 Reset mid-acknowledge SHALL abort to IDLE with no vector_valid pulse.

Configuration
REQ-029 Macro IRQ_ROTATE_EN SHALL select automatic priority rotation.
REQ-030 With IRQ_ROTATE_EN defined, each effective eoi SHALL make the cleared channel lowest priority (next index highest); the rotation base resets to 0.
REQ-031 Without IRQ_ROTATE_EN, priority SHALL stay fixed and there SHALL be no rotation register; ports are identical in both builds.

Structure
REQ-032 Package irq_pkg SHALL hold the FSM state enum, the maximum channel count of 16, and the spurious index rule.
REQ-033 The priority encoder, including the rotation offset, SHALL be sub-module irq_priority_resolver, parametrised by NUM_IRQ.

Verification
REQ-034 Scenario 1, edge on ch0 (level_mode=0, mask=0): int_out=1; two inta pulses -> vector_idx=0, isr=8'h01, irr=0.
REQ-035 Scenario 2, irq_lines=8'h55 held, all level: acknowledge -> vector_idx=0, isr=8'h01; eoi -> isr=0; int_out reasserts.
REQ-036 Scenario 3, nesting: ch4 in service, ch2 rises -> int_out=1 and acknowledge gives 2; with ch6 raised instead, int_out stays 0.
REQ-037 Scenario 4, irq_mask=8'hFE, lines=8'hAE: int_out=0 and irr=8'hAE; unmasking ch1 -> vector_idx=1.
REQ-038 Scenario 5, spurious: ch3 falls (level) between inta pulses -> vector_idx=7, isr unchanged.
REQ-039 Scenario 6, IRQ_ROTATE_EN with ch0 and ch1 pending: acknowledge 0 then eoi, then acknowledge -> 1, and ch0 is now lowest priority; rst_n pulse during ACK2 -> no vector_valid and outputs at 0.
